// File: rtl/decode.sv
// Decode stage of the vector ASIP: instruction decode strobes plus pixel, mul,
// constant and scalar index register files with combinational read ports.
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        wr_pos_pxl,
    input  logic        we_pxl,
    input  logic        we_mul,
    input  logic [31:0] wdp1,
    input  logic [31:0] wdp2,
    input  logic [31:0] wdp3,
    input  logic [31:0] wdp4,
    input  logic [31:0] wdm1,
    input  logic [31:0] wdm2,
    input  logic [31:0] wdm3,
    input  logic [31:0] wdm4,
    output logic        wr_pxl,
    output logic        wr_pos,
    output logic        wr_mul_reg,
    output logic        alu_func,
    output logic        wr_wom,
    output logic [31:0] pix_out1,
    output logic [31:0] pix_out2,
    output logic [31:0] pix_out3,
    output logic [31:0] pix_out4,
    output logic [31:0] cte_out1,
    output logic [31:0] cte_out2,
    output logic [31:0] cte_out3,
    output logic [31:0] cte_out4,
    output logic [31:0] mul_out1,
    output logic [31:0] mul_out2,
    output logic [31:0] mul_out3,
    output logic [31:0] mul_out4,
    output logic [31:0] mul_out5,
    output logic [31:0] mul_out6,
    output logic [31:0] mul_out7,
    output logic [31:0] mul_out8,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] n
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_INC   = 4'h2,
        OP_SUMFV = 4'h3,
        OP_MULFV = 4'h4,
        OP_STWOM = 4'h5,
        OP_LDC   = 4'h6
    } opcode_e;

    opcode_e     opc;
    logic        d;
    logic        s;
    logic [1:0]  sel;
    logic [31:0] imm;

    logic [31:0] pxl_q [2][4];
    logic [31:0] mul_q [2][4];
    logic [31:0] cte_q [4];
    logic [31:0] cte_d [4];
    logic [31:0] i_q, i_d;
    logic [31:0] j_q, j_d;
    logic [31:0] n_q, n_d;

    assign opc = opcode_e'(instruction[31:28]);
    assign d   = instruction[27];
    assign s   = instruction[26];
    assign sel = instruction[27:26];
    assign imm = {6'd0, instruction[25:0]};

    always_comb begin
        wr_pxl     = 1'b0;
        wr_pos     = 1'b0;
        wr_mul_reg = 1'b0;
        alu_func   = 1'b0;
        wr_wom     = 1'b0;
        i_d        = i_q;
        j_d        = j_q;
        n_d        = n_q;
        cte_d      = cte_q;
        case (opc)
            OP_LDI: begin
                case (sel)
                    2'd0:    i_d = imm;
                    2'd1:    j_d = imm;
                    2'd2:    n_d = imm;
                    default: ;
                endcase
            end
            OP_INC: begin
                case (sel)
                    2'd0:    i_d = i_q + 32'd1;
                    2'd1:    j_d = j_q + 32'd1;
                    2'd2:    n_d = n_q + 32'd1;
                    default: ;
                endcase
            end
            OP_SUMFV: begin
                wr_pxl = 1'b1;
                wr_pos = d;
            end
            OP_MULFV: begin
                wr_mul_reg = 1'b1;
                alu_func   = 1'b1;
                wr_pos     = d;
            end
            OP_STWOM: wr_wom = 1'b1;
            OP_LDC:   cte_d[sel] = imm;
            default:  ;
        endcase
    end

    // Pixel and mul write-back share the destination select but have separate enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                for (int l = 0; l < 4; l++) begin
                    pxl_q[r][l] <= 32'd0;
                    mul_q[r][l] <= 32'd0;
                end
            end
        end else begin
            if (we_pxl) begin
                pxl_q[wr_pos_pxl][0] <= wdp1;
                pxl_q[wr_pos_pxl][1] <= wdp2;
                pxl_q[wr_pos_pxl][2] <= wdp3;
                pxl_q[wr_pos_pxl][3] <= wdp4;
            end
            if (we_mul) begin
                mul_q[wr_pos_pxl][0] <= wdm1;
                mul_q[wr_pos_pxl][1] <= wdm2;
                mul_q[wr_pos_pxl][2] <= wdm3;
                mul_q[wr_pos_pxl][3] <= wdm4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) cte_q[c] <= 32'd0;
            i_q <= 32'd0;
            j_q <= 32'd0;
            n_q <= 32'd0;
        end else begin
            cte_q <= cte_d;
            i_q   <= i_d;
            j_q   <= j_d;
            n_q   <= n_d;
        end
    end

    assign pix_out1 = pxl_q[s][0];
    assign pix_out2 = pxl_q[s][1];
    assign pix_out3 = pxl_q[s][2];
    assign pix_out4 = pxl_q[s][3];
    assign cte_out1 = cte_q[0];
    assign cte_out2 = cte_q[1];
    assign cte_out3 = cte_q[2];
    assign cte_out4 = cte_q[3];
    assign mul_out1 = mul_q[0][0];
    assign mul_out2 = mul_q[0][1];
    assign mul_out3 = mul_q[0][2];
    assign mul_out4 = mul_q[0][3];
    assign mul_out5 = mul_q[1][0];
    assign mul_out6 = mul_q[1][1];
    assign mul_out7 = mul_q[1][2];
    assign mul_out8 = mul_q[1][3];
    assign i        = i_q;
    assign j        = j_q;
    assign n        = n_q;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: table-driven decode strobes through a
// scoreboard queue, plus hand-written register file and scalar sequences.
module tb_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        wr_pos_pxl, we_pxl, we_mul;
    logic [31:0] wdp1, wdp2, wdp3, wdp4;
    logic [31:0] wdm1, wdm2, wdm3, wdm4;
    logic        wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom;
    logic [31:0] pix_out1, pix_out2, pix_out3, pix_out4;
    logic [31:0] cte_out1, cte_out2, cte_out3, cte_out4;
    logic [31:0] mul_out1, mul_out2, mul_out3, mul_out4;
    logic [31:0] mul_out5, mul_out6, mul_out7, mul_out8;
    logic [31:0] i, j, n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  strobes;
    } vec_t;

    vec_t       vecs [10];
    logic [4:0] sbq [$];

    decode dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .wr_pos_pxl(wr_pos_pxl), .we_pxl(we_pxl), .we_mul(we_mul),
        .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
        .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
        .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg),
        .alu_func(alu_func), .wr_wom(wr_wom),
        .pix_out1(pix_out1), .pix_out2(pix_out2), .pix_out3(pix_out3), .pix_out4(pix_out4),
        .cte_out1(cte_out1), .cte_out2(cte_out2), .cte_out3(cte_out3), .cte_out4(cte_out4),
        .mul_out1(mul_out1), .mul_out2(mul_out2), .mul_out3(mul_out3), .mul_out4(mul_out4),
        .mul_out5(mul_out5), .mul_out6(mul_out6), .mul_out7(mul_out7), .mul_out8(mul_out8),
        .i(i), .j(j), .n(n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive all inputs at once; lane k of each write-back bus is base + k*step.
    task automatic applyStimulus(input logic [31:0] instr, input logic weP, input logic weM,
                                 input logic pos, input logic [31:0] pBase, input logic [31:0] mBase,
                                 input logic [31:0] step);
        instruction = instr;
        we_pxl      = weP;
        we_mul      = weM;
        wr_pos_pxl  = pos;
        wdp1 = pBase;          wdp2 = pBase + step;
        wdp3 = pBase + 2*step; wdp4 = pBase + 3*step;
        wdm1 = mBase;          wdm2 = mBase + step;
        wdm3 = mBase + 2*step; wdm4 = mBase + 3*step;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic checkStrobes(input string name);
        logic [4:0] expS;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            expS = sbq.pop_front();
            checkOutput(name, {27'd0, wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom}, {27'd0, expS});
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " pix1"}, pix_out1, 0); checkOutput({tag, " pix2"}, pix_out2, 0);
        checkOutput({tag, " pix3"}, pix_out3, 0); checkOutput({tag, " pix4"}, pix_out4, 0);
        checkOutput({tag, " cte1"}, cte_out1, 0); checkOutput({tag, " cte2"}, cte_out2, 0);
        checkOutput({tag, " cte3"}, cte_out3, 0); checkOutput({tag, " cte4"}, cte_out4, 0);
        checkOutput({tag, " mul1"}, mul_out1, 0); checkOutput({tag, " mul2"}, mul_out2, 0);
        checkOutput({tag, " mul3"}, mul_out3, 0); checkOutput({tag, " mul4"}, mul_out4, 0);
        checkOutput({tag, " mul5"}, mul_out5, 0); checkOutput({tag, " mul6"}, mul_out6, 0);
        checkOutput({tag, " mul7"}, mul_out7, 0); checkOutput({tag, " mul8"}, mul_out8, 0);
        checkOutput({tag, " i"}, i, 0); checkOutput({tag, " j"}, j, 0); checkOutput({tag, " n"}, n, 0);
    endtask

    initial begin
        // strobes packed as {wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom}
        vecs[0] = '{32'h0000_0000, 5'b00000};
        vecs[1] = '{32'h3000_0000, 5'b10000};
        vecs[2] = '{32'h3800_0000, 5'b11000};
        vecs[3] = '{32'h3400_0000, 5'b10000};
        vecs[4] = '{32'h4C00_0000, 5'b01110};
        vecs[5] = '{32'h4000_0000, 5'b00110};
        vecs[6] = '{32'h5000_0000, 5'b00001};
        vecs[7] = '{32'h5800_0000, 5'b00001};
        vecs[8] = '{32'h7FFF_FFFF, 5'b00000};
        vecs[9] = '{32'hF000_0000, 5'b00000};

        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) begin
            sbq.push_back(vecs[k].strobes);
            applyStimulus(vecs[k].instr, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
            #1;
            checkStrobes($sformatf("decode[%0d]", k));
        end
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();

        // Mul write-back to reg0; value must not appear before the edge.
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd15, 32'd1);
        #1;
        checkOutput("mul no bypass", mul_out1, 32'd0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        checkOutput("mul r0 l1", mul_out1, 32'd15); checkOutput("mul r0 l2", mul_out2, 32'd16);
        checkOutput("mul r0 l3", mul_out3, 32'd17); checkOutput("mul r0 l4", mul_out4, 32'd18);
        checkOutput("mul r1 empty", mul_out5, 32'd0); checkOutput("mul r1 empty l4", mul_out8, 32'd0);

        // Mul reg1 and pixel reg1 written in the same cycle; pixel reg0 beforehand.
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 32'd15, 32'd0, 32'd1);
        tick();
        applyStimulus(32'h0, 1'b1, 1'b1, 1'b1, 32'd150, 32'd150, 32'd10);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        checkOutput("mul r1 l1", mul_out5, 32'd150); checkOutput("mul r1 l2", mul_out6, 32'd160);
        checkOutput("mul r1 l3", mul_out7, 32'd170); checkOutput("mul r1 l4", mul_out8, 32'd180);
        checkOutput("mul r0 kept", mul_out1, 32'd15); checkOutput("mul r0 kept l4", mul_out4, 32'd18);

        sbq.push_back(5'b01110);
        applyStimulus(32'h4C00_0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        checkStrobes("MULFV 1 1");
        checkOutput("pix s1 l1", pix_out1, 32'd150); checkOutput("pix s1 l2", pix_out2, 32'd160);
        checkOutput("pix s1 l3", pix_out3, 32'd170); checkOutput("pix s1 l4", pix_out4, 32'd180);
        sbq.push_back(5'b00110);
        applyStimulus(32'h4000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        checkStrobes("MULFV 0 0");
        checkOutput("pix s0 l1", pix_out1, 32'd15); checkOutput("pix s0 l2", pix_out2, 32'd16);
        checkOutput("pix s0 l3", pix_out3, 32'd17); checkOutput("pix s0 l4", pix_out4, 32'd18);

        // Scalar loads, constant load, sel=11 no-op, held increment.
        applyStimulus(32'h1000_0005, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h1BFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h6800_0007, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h1C00_0123, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        checkOutput("LDI i", i, 32'd5);
        checkOutput("LDI n", n, 32'h03FF_FFFF);
        checkOutput("LDI j untouched", j, 32'd0);
        checkOutput("LDC c2", cte_out3, 32'd7);
        checkOutput("LDC c0 untouched", cte_out1, 32'd0);
        applyStimulus(32'h2000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick(); tick(); tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        checkOutput("INC i x3", i, 32'd8);

        // Preload j with all-ones by overriding its next-state for one edge, then wrap.
        applyStimulus(32'h1400_0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        force dut.j_d = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.j_d;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        checkOutput("j preload", j, 32'hFFFF_FFFF);
        applyStimulus(32'h2400_0000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        checkOutput("INC j wrap", j, 32'd0);
        checkOutput("i kept after j inc", i, 32'd8);

        // Asynchronous reset mid-cycle with writes pending; decode stays live.
        sbq.push_back(5'b10000);
        applyStimulus(32'h3000_0000, 1'b1, 1'b1, 1'b0, 32'd99, 32'd99, 32'd1);
        rst = 1'b1;
        #1;
        checkAllZero("async rst");
        checkStrobes("decode in rst");
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("pxl write ignored in rst", pix_out1, 32'd0);
        checkOutput("mul write ignored in rst", mul_out1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
